rk256_store: RTL and testbench
==============================

# rk256_store

Round-key store between `key256_exp` and the AES-256 round datapath. It captures the 15 expanded round keys that `key256_exp` emits on `rk256` / `rk256_count` / `rk256_le`. It tracks how many keys are loaded and in-order, and serves any round key to the cipher through a registered request/valid read port. The read port can be used while expansion is still running, so encryption may start before the full schedule exists.

## Interface

Parameters:

- `NKEYS`, 15: number of round keys held (AES-256: rounds 0..14).
- `AW`, 4: index width for `rk256_count` and `rd_round`.

Ports:

- `mclk` in 1: clock; all logic on the rising edge.
- `srst_n` in 1: reset, synchronous and active-low.
- `clear` in 1: one-cycle pulse invalidating all keys; driven alongside `key256_exp` `start`.
- `rk256` in 128: round key from the expander, bit 0 = MSB.
- `rk256_count` in AW: round index of `rk256`.
- `rk256_le` in 1: `rk256` / `rk256_count` are valid this cycle.
- `rd_req` in 1: level request; held until `rd_valid`.
- `rd_round` in AW: round index requested; stable while `rd_req` is high.
- `rd_key` out 128: returned round key.
- `rd_valid` out 1: `rd_key` holds the key for the pending request; one-cycle pulse per served request.
- `keys_ready` out 1: all NKEYS keys loaded.
- `load_err` out 1: sticky; an out-of-order or out-of-range write was dropped.

## Operation

- **Storage:** NKEYS x 128 register array. Contents are not reset.
- **Load counter:** `nloaded`, 0..NKEYS. Key index i is valid iff i < `nloaded`.
- **States:** EMPTY (`nloaded`=0), LOADING (0<`nloaded`<NKEYS), READY (`nloaded`=NKEYS).
  - EMPTY -> LOADING on the first accepted write.
  - LOADING -> READY on the write of index NKEYS-1.
  - Any state -> EMPTY on `clear` or reset.
- **Write acceptance:** a write is accepted iff `rk256_le`=1, `clear`=0, state != READY, and `rk256_count`==`nloaded`.
  - On acceptance: `mem[nloaded]` <= `rk256` and `nloaded` increments.
- **Write rejection:** any other `rk256_le`=1 write without `clear` is dropped and sets `load_err`. This covers wrong order, index >= NKEYS, and writes while READY.
- **`load_err`** clears only on `clear` or reset.
- **`clear` with simultaneous `rk256_le`:** `clear` wins; the write is dropped and does not set `load_err`.
- **`keys_ready`:** equals (state == READY), registered.
- **Read service:** a pending request (`rd_req`=1, no `rd_valid` in the current cycle) is served when `rd_round` < `nloaded`.
  - On service: `rd_key` <= `mem[rd_round]` and `rd_valid` <= 1.
- **Write bypass:** if the request's index is being accepted as a write this same cycle, the request is served anyway with `rd_key` <= `rk256`.
- **Unloaded index:** a request for an index not yet loaded stalls. `rd_valid` stays 0 and `rd_key` holds its last value.
- **Out-of-range read:** `rd_round` >= NKEYS never completes. The requester must not issue it.
- **`clear` during a stalled or served-this-cycle request:** the request is not served in the `clear` cycle. It resumes once the index is reloaded.
- **Back-to-back requests:** after `rd_valid` the requester may present a new `rd_round` in the same cycle `rd_valid` is high. That cycle is not a service cycle, so the maximum throughput is one key per 2 cycles.

## Timing

- **Reset values:** `rd_key`=0, `rd_valid`=0, `keys_ready`=0, `load_err`=0, `nloaded`=0, state EMPTY.
- **Read latency:** `rd_valid` rises 1 cycle after the edge where a serviceable request is sampled.
- **Write-to-status latency:**
  - `keys_ready` rises 1 cycle after the edge accepting index NKEYS-1.
  - `load_err` rises 1 cycle after the offending edge.
- **`clear` effect:** `keys_ready` and `load_err` are 0 from the cycle after `clear`. A read of index 0 stalls from that edge on.
- **Reset mid-load or mid-read:** everything returns to reset values next edge. Pending requests are dropped, and the requester re-requests.

## Test plan

- **Full load:** `clear`, then feed the FIPS-197 A.3 schedule for key 603deb10...0914dff4, indices 0..14 on consecutive cycles.
  - `keys_ready`=1 one cycle after index 14.
  - Reads return round 0 = 603deb1015ca71be2b73aef0857d7781, round 1 = 1f352c073b6108d72d9810a30914dff4, round 2 = 9ba354118e6925afa51a8b5f2067fcde, round 14 = fe4890d1e6188d0b046df344706c631e, each with `rd_valid` one cycle after the request.
- **Early read / bypass:** request round 3 before loading starts.
  - `rd_valid` stays 0 through the write of index 2.
  - When index 3 is written, `rd_valid` rises the next cycle with `rd_key` equal to the round-3 value, via bypass.
- **Out-of-order write:** write index 0, then index 2.
  - Index 2 is dropped, `load_err`=1, `nloaded` stays 1.
  - A subsequent index-1 write is accepted and `load_err` stays 1.
- **Clear collision:** assert `clear` together with a write of index 0 while READY.
  - `keys_ready`=0 and `load_err`=0 next cycle.
  - A read of round 0 stalls until index 0 is rewritten.
- **Extra write while READY:** after a full load, pulse `rk256_le` with count 5.
  - `load_err`=1 and round 5 contents are unchanged.
- **Reset mid-load:** drop `srst_n` for 1 cycle after index 7.
  - All outputs return to 0.
  - Reloading 0..14 restores READY and the correct round 14 value.

Source files
------------

// File: rtl/rk256_store.sv
// rk256_store: AES-256 round-key store.
// Captures the expanded round keys from key256_exp in index order and serves
// them to the round datapath through a registered request/valid read port.
// Reads may start while expansion is still running. A read of the index that
// is being written in the same cycle is served from the write data.
//
// state     | meaning
// ----------+---------------------------------------------
// S_EMPTY   | no keys loaded (nloaded == 0)
// S_LOADING | some keys loaded (0 < nloaded < NKEYS)
// S_READY   | full schedule loaded (nloaded == NKEYS)
module rk256_store #(
    parameter int NKEYS = 15,
    parameter int AW    = 4
) (
    input  logic          mclk,
    input  logic          srst_n,
    input  logic          clear,
    input  logic [0:127]  rk256,
    input  logic [AW-1:0] rk256_count,
    input  logic          rk256_le,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_round,
    output logic [0:127]  rd_key,
    output logic          rd_valid,
    output logic          keys_ready,
    output logic          load_err
);

    // One extra bit so the load counter can reach NKEYS itself.
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] LAST_IDX = NW'(NKEYS - 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_READY   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [NW-1:0] nloaded;
    logic [0:127]  mem [NKEYS];

    logic wr_acc;
    logic wr_rej;
    logic rd_bypass;
    logic rd_hit;
    logic rd_serve;

    // State register.
    always_ff @(posedge mclk) begin
        if (!srst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clear always wins, otherwise advance on an accepted write.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_EMPTY;
        end else if (wr_acc) begin
            state_nxt = (nloaded == LAST_IDX) ? S_READY : S_LOADING;
        end
    end

    // Write acceptance/rejection and read-service decisions for this cycle.
    always_comb begin
        wr_acc    = rk256_le && !clear && (state != S_READY)
                    && ({1'b0, rk256_count} == nloaded);
        wr_rej    = rk256_le && !clear && !wr_acc;
        rd_bypass = wr_acc && (rd_round == rk256_count);
        rd_hit    = ({1'b0, rd_round} < nloaded) || rd_bypass;
        // The cycle rd_valid is high is never a service cycle, so a held
        // request is served exactly once.
        rd_serve  = rd_req && !rd_valid && !clear && rd_hit;
    end

    // Load counter, status flags and the registered read port.
    always_ff @(posedge mclk) begin
        if (!srst_n) begin
            nloaded    <= '0;
            keys_ready <= 1'b0;
            load_err   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_key     <= '0;
        end else begin
            keys_ready <= (state_nxt == S_READY);
            rd_valid   <= rd_serve;
            if (clear) begin
                nloaded  <= '0;
                load_err <= 1'b0;
            end else begin
                if (wr_acc) begin
                    nloaded <= nloaded + NW'(1);
                end
                if (wr_rej) begin
                    load_err <= 1'b1;
                end
            end
            if (rd_serve) begin
                rd_key <= rd_bypass ? rk256 : mem[rd_round];
            end
        end
    end

    // Key storage; contents are deliberately left unreset.
    always_ff @(posedge mclk) begin
        if (wr_acc) begin
            mem[nloaded[AW-1:0]] <= rk256;
        end
    end

endmodule

// File: tb/tb_rk256_store.sv
// tb_rk256_store: directed self-checking bench for rk256_store using the
// FIPS-197 AES-256 key schedule for key 603deb10...0914dff4.
module tb_rk256_store;

    logic          mclk = 1'b0;
    logic          srst_n;
    logic          clear;
    logic [0:127]  rk256;
    logic [3:0]    rk256_count;
    logic          rk256_le;
    logic          rd_req;
    logic [3:0]    rd_round;
    logic [0:127]  rd_key;
    logic          rd_valid;
    logic          keys_ready;
    logic          load_err;

    logic [127:0] sched [15];
    int nchk  = 0;
    int nfail = 0;

    rk256_store #(.NKEYS(15), .AW(4)) dut (
        .mclk        (mclk),
        .srst_n      (srst_n),
        .clear       (clear),
        .rk256       (rk256),
        .rk256_count (rk256_count),
        .rk256_le    (rk256_le),
        .rd_req      (rd_req),
        .rd_round    (rd_round),
        .rd_key      (rd_key),
        .rd_valid    (rd_valid),
        .keys_ready  (keys_ready),
        .load_err    (load_err)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic write_key(input int idx, input logic [127:0] data);
        rk256_le    = 1'b1;
        rk256_count = 4'(idx);
        rk256       = data;
        tick();
        rk256_le    = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Single read with one idle cycle afterwards so rd_valid drops.
    task automatic read_key(input string tag, input int rnd, input logic [127:0] exp);
        rd_req   = 1'b1;
        rd_round = 4'(rnd);
        tick();
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_key"}, rd_key, exp);
        rd_req = 1'b0;
        tick();
    endtask

    initial begin
        sched[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
        sched[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
        sched[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
        sched[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
        sched[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
        sched[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
        sched[6]  = 128'h812c81addadf48ba24360af2fab8b464;
        sched[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
        sched[8]  = 128'h68007bacb2df331696e939e46c518d80;
        sched[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
        sched[10] = 128'hde1369676ccc5a71fa2563959674ee15;
        sched[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
        sched[12] = 128'h749c47ab18501ddae2757e4f7401905a;
        sched[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
        sched[14] = 128'hfe4890d1e6188d0b046df344706c631e;

        srst_n      = 1'b0;
        clear       = 1'b0;
        rk256       = '0;
        rk256_count = '0;
        rk256_le    = 1'b0;
        rd_req      = 1'b0;
        rd_round    = '0;
        tick();
        tick();
        srst_n = 1'b1;

        // Reset values
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_key", rd_key, 0);
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_load_err", load_err, 0);

        // Full load, indices 0..14 on consecutive cycles
        pulse_clear();
        for (int i = 0; i < 15; i++) begin
            rk256_le    = 1'b1;
            rk256_count = 4'(i);
            rk256       = sched[i];
            tick();
            if (i == 13) chk("full_ready_early", keys_ready, 0);
        end
        rk256_le = 1'b0;
        chk("full_keys_ready", keys_ready, 1);
        chk("full_load_err", load_err, 0);
        read_key("full_r0", 0, sched[0]);
        read_key("full_r1", 1, sched[1]);
        read_key("full_r2", 2, sched[2]);
        read_key("full_r14", 14, sched[14]);

        // Extra write while READY is dropped and flagged
        write_key(5, 128'hdeadbeef_deadbeef_deadbeef_deadbeef);
        tick();
        chk("ready_wr_err", load_err, 1);
        chk("ready_wr_ready", keys_ready, 1);
        read_key("ready_wr_r5", 5, sched[5]);

        // Clear collides with an index-0 write while READY
        clear       = 1'b1;
        rk256_le    = 1'b1;
        rk256_count = 4'd0;
        rk256       = 128'h0123456789abcdef0123456789abcdef;
        tick();
        clear    = 1'b0;
        rk256_le = 1'b0;
        chk("coll_keys_ready", keys_ready, 0);
        chk("coll_load_err", load_err, 0);
        rd_req   = 1'b1;
        rd_round = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("coll_r0_stall", rd_valid, 0);
        end
        write_key(0, sched[0]);
        chk("coll_r0_valid", rd_valid, 1);
        chk("coll_r0_key", rd_key, sched[0]);
        rd_req = 1'b0;
        tick();
        chk("coll_err_after", load_err, 0);

        // Out-of-order write
        pulse_clear();
        write_key(0, sched[0]);
        write_key(2, sched[2]);
        chk("ooo_err", load_err, 1);
        chk("ooo_nloaded1", dut.nloaded, 1);
        write_key(1, sched[1]);
        chk("ooo_err_sticky", load_err, 1);
        chk("ooo_nloaded2", dut.nloaded, 2);
        read_key("ooo_r1", 1, sched[1]);
        rd_req   = 1'b1;
        rd_round = 4'd2;
        tick();
        tick();
        chk("ooo_r2_stall", rd_valid, 0);
        rd_req = 1'b0;
        tick();

        // Early read of round 3, served via bypass
        rd_req   = 1'b1;
        rd_round = 4'd3;
        pulse_clear();
        chk("early_clr_stall", rd_valid, 0);
        chk("early_clr_err", load_err, 0);
        for (int i = 0; i < 3; i++) begin
            write_key(i, sched[i]);
            chk("early_stall", rd_valid, 0);
        end
        write_key(3, sched[3]);
        chk("early_valid", rd_valid, 1);
        chk("early_key", rd_key, sched[3]);
        rd_req = 1'b0;
        tick();
        chk("early_valid_pulse", rd_valid, 0);

        // Reset mid-load, with a pending error and a stalled read
        for (int i = 4; i < 8; i++) write_key(i, sched[i]);
        write_key(9, sched[9]);
        chk("mid_err_set", load_err, 1);
        rd_req   = 1'b1;
        rd_round = 4'd10;
        srst_n   = 1'b0;
        tick();
        srst_n = 1'b1;
        rd_req = 1'b0;
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_key", rd_key, 0);
        chk("mid_rst_keys_ready", keys_ready, 0);
        chk("mid_rst_load_err", load_err, 0);
        chk("mid_rst_nloaded", dut.nloaded, 0);
        for (int i = 0; i < 15; i++) write_key(i, sched[i]);
        chk("reload_keys_ready", keys_ready, 1);
        chk("reload_load_err", load_err, 0);
        read_key("reload_r14", 14, sched[14]);
        read_key("reload_r7", 7, sched[7]);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
